// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the MEM stage and the data memory.
// The master drives the request and the slave returns ready/err/busy and the load data.
interface data_mem_unit_if #(
  parameter int unsigned N = 32
);
  logic         req;
  logic         we;
  logic [1:0]   size;
  logic         sign_ext;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic [N-1:0] rdata;
  logic         ready;
  logic         err;
  logic         busy;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/data_mem_unit.sv
// Byte-addressable little-endian data memory built from N/8 byte banks.
// Row-crossing accesses take two beats: the lower row first, then the upper row.
module data_mem_unit #(
  parameter int unsigned N                = 32,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned ALLOW_MISALIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_unit_if.slave   bus
);
  localparam int unsigned NB    = N / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned ROWW  = ADDR_WIDTH - OFFW;
  localparam int unsigned DEPTH = 2 ** ROWW;
  localparam int unsigned IW    = $clog2(N);

  typedef enum logic [1:0] {IDLE, SPLIT, RESP} state_t;

  state_t         r_state;
  logic           r_we, r_sign, r_ready, r_err, r_busy;
  logic [1:0]     r_size;
  logic [N-1:0]   r_addr, r_wdata, r_rdata;
  logic [7:0]     r_buf [NB];
  logic [7:0]     r_mem [NB][DEPTH];

  logic           w_idle, w_we, w_sign, w_cross, w_err, w_wr_go, w_msb;
  logic [1:0]     w_size;
  logic [N-1:0]   w_addr, w_wdata, w_merged, w_ext;
  logic [OFFW-1:0] w_off;
  logic [ROWW-1:0] w_row;
  int unsigned    w_nbytes;
  logic [NB-1:0]  w_bk_en, w_lane_v;
  logic [OFFW-1:0] w_bk_k   [NB];
  logic [ROWW-1:0] w_bk_row [NB];
  logic [7:0]     w_bk_wd  [NB];
  logic [7:0]     w_lane   [NB];

  assign w_idle = (r_state == IDLE);

  // Current beat uses live inputs in IDLE and the captured request afterwards.
  always_comb begin
    w_we    = r_we;
    w_size  = r_size;
    w_sign  = r_sign;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    if (w_idle) begin
      w_we    = bus.we;
      w_size  = bus.size;
      w_sign  = bus.sign_ext;
      w_addr  = bus.addr;
      w_wdata = bus.wdata;
    end
  end

  assign w_off = w_addr[OFFW-1:0];
  assign w_row = w_addr[ADDR_WIDTH-1:OFFW];

  always_comb begin
    w_nbytes = 1;
    case (w_size)
      2'b01:   w_nbytes = 2;
      2'b10:   w_nbytes = NB;
      default: w_nbytes = 1;
    endcase
  end

  assign w_cross = (32'(w_off) + w_nbytes) > NB;
  assign w_err   = (w_size == 2'b11)
                 || ((w_addr >> ADDR_WIDTH) != '0)
                 || ((32'(w_addr[ADDR_WIDTH-1:0]) + w_nbytes - 1) > (2 ** ADDR_WIDTH - 1))
                 || (w_cross && (ALLOW_MISALIGNED == 0));
  assign w_wr_go = !rst && w_we && ((w_idle && bus.req && !w_err) || (r_state == SPLIT));

  // Map banks to access bytes: lower-row bytes in IDLE, upper-row bytes in SPLIT.
  always_comb begin
    w_lane_v = '0;
    w_bk_en  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      w_bk_k[b]   = '0;
      w_bk_row[b] = w_row;
      w_lane[b]   = 8'h00;
    end
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_idle) begin
        if ((b >= 32'(w_off)) && ((b - 32'(w_off)) < w_nbytes)) begin
          w_bk_en[b] = 1'b1;
          w_bk_k[b]  = OFFW'(b - 32'(w_off));
        end
      end else if ((b < 32'(w_off)) && ((b + NB - 32'(w_off)) < w_nbytes)) begin
        w_bk_en[b]  = 1'b1;
        w_bk_k[b]   = OFFW'(b + NB - 32'(w_off));
        w_bk_row[b] = w_row + ROWW'(1);
      end
      w_bk_wd[b] = w_wdata[IW'(8 * 32'(w_bk_k[b])) +: 8];
      if (w_bk_en[b]) begin
        w_lane[w_bk_k[b]]   = r_mem[b][w_bk_row[b]];
        w_lane_v[w_bk_k[b]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NB; k++) begin
      w_merged[IW'(8 * k) +: 8] = w_lane_v[k] ? w_lane[k] : r_buf[k];
    end
  end

  always_comb begin
    w_msb = w_merged[IW'(8 * w_nbytes - 1)];
    w_ext = w_merged;
    for (int unsigned i = 0; i < N; i++) begin
      if (i >= 8 * w_nbytes) w_ext[i] = w_sign & w_msb;
    end
  end

  // Byte banks are never reset; each bank takes at most one byte per beat.
  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    always_ff @(posedge clk) begin
      if (w_wr_go && w_bk_en[gb]) r_mem[gb][w_bk_row[gb]] <= w_bk_wd[gb];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (bus.req) begin
            r_we    <= bus.we;
            r_size  <= bus.size;
            r_sign  <= bus.sign_ext;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            for (int unsigned k = 0; k < NB; k++) r_buf[k] <= w_merged[IW'(8 * k) +: 8];
            if (w_err) begin
              r_err   <= 1'b1;
              r_ready <= 1'b1;
              r_state <= RESP;
            end else if (w_cross) begin
              r_state <= SPLIT;
            end else begin
              r_ready <= 1'b1;
              r_state <= RESP;
              if (!bus.we) r_rdata <= w_ext;
            end
          end
        end
        SPLIT: begin
          r_ready <= 1'b1;
          r_state <= RESP;
          if (!r_we) r_rdata <= w_ext;
        end
        RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: one instance with split accesses enabled, one with them disabled.
module tb_data_mem_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_unit_if #(.N(32)) bus_a ();
  data_mem_unit_if #(.N(32)) bus_b ();

  data_mem_unit #(.N(32), .ADDR_WIDTH(12), .ALLOW_MISALIGNED(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  data_mem_unit #(.N(32), .ADDR_WIDTH(12), .ALLOW_MISALIGNED(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic        t_sel, t_req, t_we, t_sgn;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;

  assign bus_a.req = t_req & ~t_sel;
  assign bus_b.req = t_req & t_sel;
  assign bus_a.we = t_we;      assign bus_b.we = t_we;
  assign bus_a.size = t_size;  assign bus_b.size = t_size;
  assign bus_a.sign_ext = t_sgn; assign bus_b.sign_ext = t_sgn;
  assign bus_a.addr = t_addr;  assign bus_b.addr = t_addr;
  assign bus_a.wdata = t_wdata; assign bus_b.wdata = t_wdata;

  logic        m_ready, m_err, m_busy;
  logic [31:0] m_rdata;
  assign m_ready = t_sel ? bus_b.ready : bus_a.ready;
  assign m_err   = t_sel ? bus_b.err   : bus_a.err;
  assign m_busy  = t_sel ? bus_b.busy  : bus_a.busy;
  assign m_rdata = t_sel ? bus_b.rdata : bus_a.rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          sel;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit sel, bit we, logic [1:0] size, bit sgn, logic [31:0] addr,
                              logic [31:0] wdata, int lat, bit err, bit chk_rd, logic [31:0] rd);
    vec_t v;
    v.sel = sel; v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.lat = lat; v.err = err; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    t_sel = v.sel; t_req = 1'b1; t_we = v.we; t_size = v.size; t_sgn = v.sgn;
    t_addr = v.addr; t_wdata = v.wdata;
    @(posedge clk); #1;
    t_req = 1'b0;
    lat = 1;
    while (!m_ready && lat < 4) begin
      chk($sformatf("vec%0d_busy_wait", idx), 32'(m_busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("vec%0d_err", idx), 32'(m_err), 32'(v.err));
    chk($sformatf("vec%0d_busy_resp", idx), 32'(m_busy), 32'd1);
    if (v.chk_rd) chk($sformatf("vec%0d_rdata", idx), m_rdata, v.rd);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_ready_pulse", idx), 32'(m_ready), 32'd0);
    chk($sformatf("vec%0d_busy_idle", idx), 32'(m_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    t_sel = 1'b0; t_req = 1'b0; t_we = 1'b0; t_size = 2'b00; t_sgn = 1'b0;
    t_addr = '0; t_wdata = '0;
    rst = 1'b1;

    // A: split-capable instance
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h010, 32'h0,        1, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 2'b00, 1, 32'h013, 32'h0,        1, 0, 1, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h013, 32'h0,        1, 0, 1, 32'h000000DE));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h012, 32'h0,        1, 0, 1, 32'hFFFFDEAD));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h020, 32'h55667788, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h024, 32'h99AABBCC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h021, 32'h11223344, 2, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h020, 32'h0,        1, 0, 1, 32'h22334488));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h024, 32'h0,        1, 0, 1, 32'h99AABB11));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h022, 32'h0,        2, 0, 1, 32'hBB112233));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h023, 32'h0,        2, 0, 1, 32'h00001122));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'h025, 32'h0,        1, 0, 1, 32'hFFFFAABB));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h026, 32'hFFFFFF7F, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h024, 32'h0,        1, 0, 1, 32'h997FBB11));
    // illegal requests keep rdata and memory intact
    vecs.push_back(mk(0, 0, 2'b11, 0, 32'h000, 32'h0,        1, 1, 1, 32'h997FBB11));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'hFFE, 32'h0,        1, 1, 1, 32'h997FBB11));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'h1000, 32'h0,       1, 1, 1, 32'h997FBB11));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h010, 32'h00000000, 1, 1, 1, 32'h997FBB11));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h80000010, 32'h0,   1, 1, 1, 32'h997FBB11));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h010, 32'h0,        1, 0, 1, 32'hDEADBEEF));
    // top-of-memory boundary
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'hFFC, 32'h0,        1, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 2'b00, 0, 32'hFFF, 32'h0,        1, 0, 1, 32'h000000CA));
    vecs.push_back(mk(0, 0, 2'b01, 1, 32'hFFF, 32'h0,        1, 1, 1, 32'h000000CA));
    // B: row-crossing is rejected
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h020, 32'h55667788, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h024, 32'h99AABBCC, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h021, 32'h11223344, 1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h020, 32'h0,        1, 0, 1, 32'h55667788));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h024, 32'h0,        1, 0, 1, 32'h99AABBCC));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h023, 32'h0,        1, 1, 1, 32'h99AABBCC));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h022, 32'h0,        1, 0, 1, 32'h00005566));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_a", 32'(bus_a.ready), 32'd0);
    chk("reset_err_a",   32'(bus_a.err),   32'd0);
    chk("reset_busy_a",  32'(bus_a.busy),  32'd0);
    chk("reset_rdata_a", bus_a.rdata,      32'd0);
    chk("reset_busy_b",  32'(bus_b.busy),  32'd0);
    chk("reset_rdata_b", bus_b.rdata,      32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset during SPLIT of a row-crossing store
    @(negedge clk);
    t_sel = 1'b0; t_req = 1'b1; t_we = 1'b1; t_size = 2'b10; t_sgn = 1'b0;
    t_addr = 32'h023; t_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    t_req = 1'b0;
    chk("rst_split_busy", 32'(m_busy), 32'd1);
    chk("rst_split_noready", 32'(m_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_split_busy_after", 32'(m_busy), 32'd0);
    chk("rst_split_ready_after", 32'(m_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_split_no_pulse%0d", c), 32'(m_ready), 32'd0);
    end
    apply(mk(0, 0, 2'b10, 0, 32'h020, 32'h0, 1, 0, 1, 32'hDD334488), 100);
    apply(mk(0, 0, 2'b10, 0, 32'h024, 32'h0, 1, 0, 1, 32'h997FBB11), 101);

    // req held high: re-accepted only in the idle cycle after ready
    @(negedge clk);
    t_sel = 1'b0; t_req = 1'b1; t_we = 1'b0; t_size = 2'b10; t_sgn = 1'b0;
    t_addr = 32'h010; t_wdata = '0;
    @(posedge clk); #1;
    chk("hold_ready1", 32'(m_ready), 32'd1);
    chk("hold_busy1",  32'(m_busy),  32'd1);
    chk("hold_rdata1", m_rdata, 32'hDEADBEEF);
    t_addr = 32'h020;
    @(posedge clk); #1;
    chk("hold_ready2", 32'(m_ready), 32'd0);
    chk("hold_busy2",  32'(m_busy),  32'd0);
    chk("hold_rdata2", m_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    t_req = 1'b0;
    chk("hold_ready3", 32'(m_ready), 32'd1);
    chk("hold_rdata3", m_rdata, 32'hDD334488);
    @(posedge clk); #1;
    chk("hold_ready4", 32'(m_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold_ready5", 32'(m_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
